reg_file_2r1w: RTL and testbench
================================

REG_FILE_2R1W -- requirements
Module: reg_file_2r1w

Interface
REQ-001 SHALL have parameter DATA_W, default 8, entry width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 16, number of entries (2..256); ADDR_W = clog2(DEPTH), derived as a localparam.
REQ-003 SHALL have port Clk, in, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port Rst, in, 1, reset; asynchronous and active-low.
REQ-005 SHALL have ports W_en in 1, W_Addr in ADDR_W, W_Data in DATA_W, the write port.
REQ-006 SHALL have ports RA_en in 1, RA_Addr in ADDR_W, RA_Data out DATA_W, RA_Valid out 1, read port A.
REQ-007 SHALL have ports RB_en, RB_Addr, RB_Data, RB_Valid, read port B, same widths as port A.
REQ-008 SHALL have port Clr, in, 1, synchronous clear of all entries.
REQ-009 SHALL have ports Dump_start in 1, Dump_ready in 1, Dump_valid out 1, Dump_addr out ADDR_W, Dump_data out DATA_W, Dump_busy out 1, Dump_done out 1, the serial dump stream.

Function
REQ-010 SHALL perform a write at the clock edge when W_en=1, Clr=0 and W_Addr<DEPTH; otherwise no entry changes.
REQ-011 SHALL zero all entries at the clock edge when Clr=1; Clr has priority over a simultaneous write.
REQ-012 SHALL register reads with a latency of 1: RX_Data and RX_Valid=1 one cycle after RX_en=1.
REQ-013 SHALL hold RX_Data and drive RX_Valid=0 in the cycle after RX_en=0; outputs are never Z.
REQ-014 SHALL return 0 for a read with RX_Addr>=DEPTH, with RX_Valid=1.
REQ-015 SHALL allow both read ports to read any addresses, including the same address, in the same cycle.
REQ-016 SHALL implement dump FSM states IDLE, SCAN, DONE.
REQ-017 SHALL move from IDLE to SCAN on Dump_start=1, with Dump_addr=0; Dump_start SHALL be ignored outside IDLE.
REQ-018 SHALL in SCAN assert Dump_valid=1 and Dump_busy=1, with Dump_data a registered snapshot of entry Dump_addr.
REQ-019 SHALL hold Dump_addr and Dump_data stable while Dump_valid=1 and Dump_ready=0, even if that entry is written or cleared.
REQ-020 SHALL on Dump_valid&Dump_ready increment Dump_addr and load the new snapshot, reflecting any write or clear committed at that same edge.
REQ-021 SHALL on the handshake at Dump_addr=DEPTH-1 go to DONE, which lasts one cycle with Dump_done=1, Dump_busy=1 and Dump_valid=0, then return to IDLE.
REQ-022 SHALL not stall the read or write ports during a dump.

Reset
REQ-023 SHALL on Rst=0 immediately zero all entries, set RA_Data/RB_Data=0, RA_Valid/RB_Valid=0, FSM=IDLE, and Dump_addr, Dump_data, Dump_valid, Dump_busy, Dump_done all 0.
REQ-024 SHALL abort a dump in progress when reset occurs mid-SCAN, with no Dump_done pulse.

Configuration
REQ-025 SHALL with REGFILE_BYPASS_EN defined, when a read and a write hit the same in-range address in the same cycle, return W_Data at the next cycle (write-through); with Clr=1, return 0.
REQ-026 SHALL without REGFILE_BYPASS_EN return the pre-write stored value in that case.

Structure
REQ-027 SHALL place the dump-state enum (IDLE/SCAN/DONE) and a clog2 helper in shared package regfile_pkg.
REQ-028 SHALL implement the dump FSM as sub-module regfile_dump_ctrl; the storage array and read ports stay in reg_file_2r1w.

Verification
REQ-029 SHALL cover: reset, write 0x5A to addr 3, RA read addr 3 -> next cycle RA_Data=0x5A, RA_Valid=1.
REQ-030 SHALL cover: a same-cycle write of 0x11 and RA read to addr 7 (old value 0x22) -> RA_Data=0x11 with the bypass macro, 0x22 without it.
REQ-031 SHALL cover: write i+1 to every addr i, Dump_start, Dump_ready=1 -> 16 beats of addr 0..15 / data 1..16, then Dump_done for one cycle and Dump_busy=0 after it.
REQ-032 SHALL cover: a dump with Dump_ready held 0 at addr 4 while addr 4 is written 0xFF -> Dump_data stays 0x05 until the handshake.
REQ-033 SHALL cover: Clr and W_en asserted together at addr 2 -> all entries read 0.
REQ-034 SHALL cover: Rst=0 pulse mid-SCAN -> outputs 0 immediately, no Dump_done, and a subsequent Dump_start restarts at addr 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the 2-read/1-write register file: dump FSM state
// encoding and a constant-evaluable ceiling-log2 helper for address widths.
package regfile_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } dump_state_e;

    // Smallest n with 2**n >= value; usable in parameter/localparam context.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Serial dump controller: walks entries 0..DEPTH-1 with a valid/ready
// stream, holding a registered snapshot of the current entry while stalled.
// The parent supplies the post-edge value of the entry at snap_addr_o, so a
// snapshot taken at a handshake already reflects a same-edge write or clear.
module regfile_dump_ctrl
    import regfile_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Dump_start,
    input  logic              Dump_ready,
    input  logic [DATA_W-1:0] snap_data_i,
    output logic [ADDR_W-1:0] snap_addr_o,
    output logic              Dump_valid,
    output logic [ADDR_W-1:0] Dump_addr,
    output logic [DATA_W-1:0] Dump_data,
    output logic              Dump_busy,
    output logic              Dump_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    // State, address and snapshot registers; reset aborts any dump silently.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic; snap_addr_o names the entry that would be loaded.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        snap_addr_o = '0;
        case (state_q)
            IDLE: begin
                if (Dump_start) begin
                    state_d = SCAN;
                    addr_d  = '0;
                    data_d  = snap_data_i;
                end
            end
            SCAN: begin
                // Never request an index past the last entry.
                if (addr_q != LAST_ADDR) begin
                    snap_addr_o = addr_q + ADDR_ONE;
                end
                if (Dump_ready) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = DONE;
                        addr_d  = '0;
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                        data_d = snap_data_i;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Dump_valid = (state_q == SCAN);
    assign Dump_busy  = (state_q != IDLE);
    assign Dump_done  = (state_q == DONE);
    assign Dump_addr  = addr_q;
    assign Dump_data  = data_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// Register file with one write port, two registered read ports (latency 1)
// and a serial dump stream. Storage is flop-based so reset and Clr can zero
// every entry at once.
// Optional macro REGFILE_BYPASS_EN: a read that hits the address written in
// the same cycle returns the new data (or 0 under Clr) instead of the old.
module reg_file_2r1w
    import regfile_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              W_en,
    input  logic [ADDR_W-1:0] W_Addr,
    input  logic [DATA_W-1:0] W_Data,
    input  logic              RA_en,
    input  logic [ADDR_W-1:0] RA_Addr,
    output logic [DATA_W-1:0] RA_Data,
    output logic              RA_Valid,
    input  logic              RB_en,
    input  logic [ADDR_W-1:0] RB_Addr,
    output logic [DATA_W-1:0] RB_Data,
    output logic              RB_Valid,
    input  logic              Clr,
    input  logic              Dump_start,
    input  logic              Dump_ready,
    output logic              Dump_valid,
    output logic [ADDR_W-1:0] Dump_addr,
    output logic [DATA_W-1:0] Dump_data,
    output logic              Dump_busy,
    output logic              Dump_done
);

    // DEPTH widened by one bit so any address value compares without overflow.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  wr_sel;
    logic [ADDR_W-1:0] snap_addr;
    logic [DATA_W-1:0] snap_data;

    // One-hot write decode; out-of-range addresses select nothing.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
        assign wr_sel[gi] = W_en && !Clr && (W_Addr == ADDR_W'(gi));
    end

    // Storage update: clear beats write.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (Clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    mem_q[i] <= W_Data;
                end
            end
        end
    end

    // Two identical read ports; index 0 is port A, index 1 is port B.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data_q, data_d;
        logic              valid_q;

        assign en   = (gi == 0) ? RA_en   : RB_en;
        assign addr = (gi == 0) ? RA_Addr : RB_Addr;

        // Read data selection; data holds when the port is idle.
        always_comb begin
            data_d = data_q;
            if (en) begin
                if ({1'b0, addr} >= DEPTH_L) begin
                    data_d = '0;
`ifdef REGFILE_BYPASS_EN
                end else if (Clr) begin
                    data_d = '0;
                end else if (W_en && (W_Addr == addr)) begin
                    data_d = W_Data;
`endif
                end else begin
                    data_d = mem_q[addr];
                end
            end
        end

        // Registered read output and its one-cycle valid flag.
        always_ff @(posedge Clk or negedge Rst) begin
            if (!Rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                data_q  <= data_d;
                valid_q <= en;
            end
        end
    end

    assign RA_Data  = g_rd[0].data_q;
    assign RA_Valid = g_rd[0].valid_q;
    assign RB_Data  = g_rd[1].data_q;
    assign RB_Valid = g_rd[1].valid_q;

    // Post-edge value of the entry the dump controller wants to snapshot.
    always_comb begin
        snap_data = '0;
        if (!Clr) begin
            if (W_en && (W_Addr == snap_addr)) begin
                snap_data = W_Data;
            end else begin
                snap_data = mem_q[snap_addr];
            end
        end
    end

    regfile_dump_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_dump_ctrl (
        .Clk         (Clk),
        .Rst         (Rst),
        .Dump_start  (Dump_start),
        .Dump_ready  (Dump_ready),
        .snap_data_i (snap_data),
        .snap_addr_o (snap_addr),
        .Dump_valid  (Dump_valid),
        .Dump_addr   (Dump_addr),
        .Dump_data   (Dump_data),
        .Dump_busy   (Dump_busy),
        .Dump_done   (Dump_done)
    );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w (DATA_W=8, DEPTH=16).
module tb_reg_file_2r1w;

    logic       Clk;
    logic       Rst;
    logic       W_en;
    logic [3:0] W_Addr;
    logic [7:0] W_Data;
    logic       RA_en;
    logic [3:0] RA_Addr;
    logic [7:0] RA_Data;
    logic       RA_Valid;
    logic       RB_en;
    logic [3:0] RB_Addr;
    logic [7:0] RB_Data;
    logic       RB_Valid;
    logic       Clr;
    logic       Dump_start;
    logic       Dump_ready;
    logic       Dump_valid;
    logic [3:0] Dump_addr;
    logic [7:0] Dump_data;
    logic       Dump_busy;
    logic       Dump_done;

    int total;
    int bad;

    reg_file_2r1w #(
        .DATA_W (8),
        .DEPTH  (16)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .W_en       (W_en),
        .W_Addr     (W_Addr),
        .W_Data     (W_Data),
        .RA_en      (RA_en),
        .RA_Addr    (RA_Addr),
        .RA_Data    (RA_Data),
        .RA_Valid   (RA_Valid),
        .RB_en      (RB_en),
        .RB_Addr    (RB_Addr),
        .RB_Data    (RB_Data),
        .RB_Valid   (RB_Valid),
        .Clr        (Clr),
        .Dump_start (Dump_start),
        .Dump_ready (Dump_ready),
        .Dump_valid (Dump_valid),
        .Dump_addr  (Dump_addr),
        .Dump_data  (Dump_data),
        .Dump_busy  (Dump_busy),
        .Dump_done  (Dump_done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_byp;
        int         n;
        total = 0;
        bad   = 0;
        Rst = 1'b0; W_en = 1'b0; W_Addr = '0; W_Data = '0;
        RA_en = 1'b0; RA_Addr = '0; RB_en = 1'b0; RB_Addr = '0;
        Clr = 1'b0; Dump_start = 1'b0; Dump_ready = 1'b0;

        // Reset state
        #2;
        check("rst_ra_data",  RA_Data, 0);
        check("rst_ra_valid", RA_Valid, 0);
        check("rst_rb_valid", RB_Valid, 0);
        check("rst_dvalid",   Dump_valid, 0);
        check("rst_dbusy",    Dump_busy, 0);
        check("rst_ddone",    Dump_done, 0);
        check("rst_daddr",    Dump_addr, 0);
        tick();
        tick();
        Rst = 1'b1;
        tick();

        // Write 0x5A to 3, read it on both ports
        W_en = 1'b1; W_Addr = 4'd3; W_Data = 8'h5A;
        tick();
        W_en = 1'b0;
        RA_en = 1'b1; RA_Addr = 4'd3; RB_en = 1'b1; RB_Addr = 4'd3;
        tick();
        check("ra_read3",   RA_Data, 8'h5A);
        check("ra_valid3",  RA_Valid, 1);
        check("rb_read3",   RB_Data, 8'h5A);
        check("rb_valid3",  RB_Valid, 1);
        RA_en = 1'b0; RB_en = 1'b0;
        tick();
        check("ra_hold",    RA_Data, 8'h5A);
        check("ra_idle",    RA_Valid, 0);

        // Same-cycle write and read at addr 7
        W_en = 1'b1; W_Addr = 4'd7; W_Data = 8'h22;
        tick();
        W_Data = 8'h11; RA_en = 1'b1; RA_Addr = 4'd7;
        tick();
        W_en = 1'b0;
`ifdef REGFILE_BYPASS_EN
        exp_byp = 8'h11;
`else
        exp_byp = 8'h22;
`endif
        check("rw_same_addr", RA_Data, exp_byp);
        tick();
        check("rw_after",     RA_Data, 8'h11);
        RA_en = 1'b0;

        // Clear with a simultaneous write to addr 2
        W_en = 1'b1; W_Addr = 4'd2; W_Data = 8'h33;
        tick();
        Clr = 1'b1; W_Data = 8'h77;
        tick();
        Clr = 1'b0; W_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            RA_en = 1'b1; RA_Addr = 4'(i);
            RB_en = 1'b1; RB_Addr = 4'(15 - i);
            tick();
            check($sformatf("clr_ra_%0d", i), RA_Data, 0);
            check($sformatf("clr_rb_%0d", 15 - i), RB_Data, 0);
        end
        RA_en = 1'b0; RB_en = 1'b0;

        // Fill i+1 and dump with ready held high
        for (int i = 0; i < 16; i++) begin
            W_en = 1'b1; W_Addr = 4'(i); W_Data = 8'(i + 1);
            tick();
        end
        W_en = 1'b0;
        Dump_start = 1'b1;
        tick();
        Dump_start = 1'b0; Dump_ready = 1'b1;
        for (int b = 0; b < 16; b++) begin
            check($sformatf("d1_valid_%0d", b), Dump_valid, 1);
            check($sformatf("d1_busy_%0d", b),  Dump_busy, 1);
            check($sformatf("d1_addr_%0d", b),  Dump_addr, b);
            check($sformatf("d1_data_%0d", b),  Dump_data, b + 1);
            tick();
        end
        check("d1_done",      Dump_done, 1);
        check("d1_done_busy", Dump_busy, 1);
        check("d1_done_vld",  Dump_valid, 0);
        Dump_ready = 1'b0;
        tick();
        check("d1_after_done", Dump_done, 0);
        check("d1_after_busy", Dump_busy, 0);

        // Dump stalled at addr 4 while addr 4 is overwritten
        Dump_start = 1'b1;
        tick();
        Dump_start = 1'b0; Dump_ready = 1'b1;
        tick(); tick(); tick(); tick();
        Dump_ready = 1'b0;
        check("d2_addr4", Dump_addr, 4);
        check("d2_data4", Dump_data, 8'h05);
        W_en = 1'b1; W_Addr = 4'd4; W_Data = 8'hFF; Dump_start = 1'b1;
        tick();
        W_en = 1'b0; Dump_start = 1'b0;
        check("d2_hold_addr", Dump_addr, 4);
        check("d2_hold_data", Dump_data, 8'h05);
        tick();
        check("d2_hold_data2", Dump_data, 8'h05);
        Dump_ready = 1'b1;
        tick();
        check("d2_addr5", Dump_addr, 5);
        check("d2_data5", Dump_data, 8'h06);
        // Write to the next entry at the handshake edge
        W_en = 1'b1; W_Addr = 4'd6; W_Data = 8'hAB;
        RA_en = 1'b1; RA_Addr = 4'd4;
        tick();
        W_en = 1'b0; RA_en = 1'b0;
        check("d2_addr6", Dump_addr, 6);
        check("d2_data6", Dump_data, 8'hAB);
        check("d2_rd4",   RA_Data, 8'hFF);
        n = 0;
        while (!Dump_done && n < 40) begin
            tick();
            n++;
        end
        check("d2_done", Dump_done, 1);
        Dump_ready = 1'b0;
        tick();
        check("d2_idle", Dump_busy, 0);

        // Reset in the middle of a scan
        Dump_start = 1'b1;
        tick();
        Dump_start = 1'b0; Dump_ready = 1'b1; RA_en = 1'b1; RA_Addr = 4'd1;
        tick();
        tick();
        check("d3_pre_addr", Dump_addr, 2);
        check("d3_pre_data", Dump_data, 8'h03);
        check("d3_pre_ra",   RA_Data, 8'h02);
        Rst = 1'b0;
        #1;
        check("d3_rst_valid", Dump_valid, 0);
        check("d3_rst_busy",  Dump_busy, 0);
        check("d3_rst_done",  Dump_done, 0);
        check("d3_rst_addr",  Dump_addr, 0);
        check("d3_rst_data",  Dump_data, 0);
        check("d3_rst_ra",    RA_Data, 0);
        check("d3_rst_rav",   RA_Valid, 0);
        Dump_ready = 1'b0; RA_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("d3_no_done_%0d", i), Dump_done, 0);
        end
        Rst = 1'b1;
        tick();
        check("d3_no_done_rel", Dump_done, 0);
        RA_en = 1'b1; RA_Addr = 4'd5;
        tick();
        RA_en = 1'b0;
        check("d3_mem_zero", RA_Data, 0);
        Dump_start = 1'b1;
        tick();
        Dump_start = 1'b0;
        check("d3_restart_valid", Dump_valid, 1);
        check("d3_restart_addr",  Dump_addr, 0);
        check("d3_restart_data",  Dump_data, 0);
        Dump_ready = 1'b1;
        n = 0;
        while (!Dump_done && n < 40) begin
            tick();
            n++;
        end
        check("d3_done", Dump_done, 1);
        Dump_ready = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
